// File: rtl/lu_serial_arbiter_pkg.sv
// Shared op codes and FSM state encodings for the serial logic-unit arbiter.
package lu_serial_arbiter_pkg;

  localparam logic [2:0] OP_NOTA = 3'b000;
  localparam logic [2:0] OP_NOTB = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_XNOR = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/lu_serial_arbiter_lu_bit8.sv
// Purely combinational 1-bit logic unit with eight selectable functions.
module lu_bit8
  import lu_serial_arbiter_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [2:0] op,
  output logic       y
);

  always_comb begin
    y = 1'b0;
    case (op)
      OP_NOTA: y = ~a;
      OP_NOTB: y = ~b;
      OP_AND:  y = a & b;
      OP_NAND: y = ~(a & b);
      OP_OR:   y = a | b;
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/lu_serial_arbiter.sv
// Round-robin arbiter sharing one 1-bit logic unit between two requesters;
// operands are streamed LSB-first and the assembled word is returned with its id.
module lu_serial_arbiter
  import lu_serial_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [5:0]         req_op,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic             id_q;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] result_q;

  logic             grant_ok;
  logic             grant_id;
  logic             lu_y;

  // Grant selection: a lone requester wins; on a tie, the one not served last.
  always_comb begin
    grant_ok = 1'b0;
    grant_id = 1'b0;
    if (state == ST_IDLE) begin
      case (req_valid)
        2'b01: begin grant_ok = 1'b1; grant_id = 1'b0;        end
        2'b10: begin grant_ok = 1'b1; grant_id = 1'b1;        end
        2'b11: begin grant_ok = 1'b1; grant_id = ~last_grant; end
        default: begin grant_ok = 1'b0; grant_id = 1'b0;      end
      endcase
    end
  end

  assign req_ready = {grant_ok & grant_id, grant_ok & ~grant_id};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_ok) begin
            last_grant <= grant_id;
            id_q       <= grant_id;
            cnt        <= '0;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= ST_DONE;
        end
        ST_DONE: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Operand capture at accept; result bits filled one per RUN cycle.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && grant_ok) begin
      a_q  <= grant_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
      b_q  <= grant_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
      op_q <= grant_id ? req_op[5:3] : req_op[2:0];
    end
    if (state == ST_RUN) result_q[cnt] <= lu_y;
  end

  lu_bit8 u_lu (
    .a  (a_q[cnt]),
    .b  (b_q[cnt]),
    .op (op_q),
    .y  (lu_y)
  );

  assign rsp_valid = (state == ST_DONE);
  assign rsp_data  = (state == ST_DONE) ? result_q : '0;
  assign rsp_id    = id_q;
  assign busy      = (state == ST_RUN) || (state == ST_DONE);

endmodule

// File: tb/tb_lu_serial_arbiter.sv
// Self-checking bench for lu_serial_arbiter: directed scenarios plus randomized
// transactions checked against a word-level reference model.
module tb_lu_serial_arbiter;

  localparam int W = 4;
  typedef logic [W-1:0]   w_t;
  typedef logic [2*W-1:0] pw_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  pw_t          req_a;
  pw_t          req_b;
  logic [5:0]   req_op;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  w_t           rsp_data;
  logic         busy;

  int checks = 0;
  int errors = 0;
  logic m_last;
  w_t   last_rsp;

  lu_serial_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic w_t ref_lu(input logic [2:0] op, input w_t a, input w_t b);
    case (op)
      3'd0: return ~a;
      3'd1: return ~b;
      3'd2: return a & b;
      3'd3: return ~(a & b);
      3'd4: return a | b;
      3'd5: return ~(a | b);
      3'd6: return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
    chk({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  // One full transaction starting from an IDLE cycle, #1 after a rising edge.
  task automatic do_txn(input logic [1:0] vld,
                        input w_t a0, input w_t b0, input logic [2:0] op0,
                        input w_t a1, input w_t b1, input logic [2:0] op1,
                        input int hold, input bit pulse, input string tag);
    logic gid;
    w_t   exp_data;
    gid      = (vld == 2'b01) ? 1'b0 : (vld == 2'b10) ? 1'b1 : ~m_last;
    exp_data = gid ? ref_lu(op1, a1, b1) : ref_lu(op0, a0, b0);
    req_valid = vld;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    req_op    = {op1, op0};
    #1;
    chk({tag, "_ready"}, 32'(req_ready), gid ? 32'd2 : 32'd1);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    m_last    = gid;
    req_valid = 2'b00;
    req_a     = pw_t'($urandom);
    req_b     = pw_t'($urandom);
    req_op    = 6'($urandom);
    chk({tag, "_run_busy"}, 32'(busy), 32'd1);
    chk({tag, "_run_ready"}, 32'(req_ready), 32'd0);
    for (int i = 1; i <= W; i++) begin
      if (pulse) req_valid = 2'($urandom_range(1, 3));
      @(posedge clk); #1;
      chk({tag, "_lat_valid"}, 32'(rsp_valid), (i < W) ? 32'd0 : 32'd1);
      chk({tag, "_lat_ready"}, 32'(req_ready), 32'd0);
    end
    chk({tag, "_id"}, 32'(rsp_id), 32'(gid));
    chk({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
    chk({tag, "_done_busy"}, 32'(busy), 32'd1);
    last_rsp = rsp_data;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_data"}, 32'(rsp_data), 32'(exp_data));
      chk({tag, "_hold_id"}, 32'(rsp_id), 32'(gid));
      chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_hold_busy"}, 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 2'b00;
    chk({tag, "_rel_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rel_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rel_data"}, 32'(rsp_data), 32'd0);
  endtask

  initial begin
    w_t exp_ops [8];
    exp_ops = '{4'b0011, 4'b0101, 4'b1000, 4'b0111, 4'b1110, 4'b0001, 4'b0110, 4'b1001};

    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    m_last    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("post_reset");

    // Ties from reset: req0, then req1, then req0 again.
    do_txn(2'b11, 4'b1100, 4'b1010, 3'b110, 4'b1100, 4'b1010, 3'b100, 0, 1'b0, "tie1");
    chk("tie1_const", 32'(last_rsp), 32'(4'b0110));
    do_txn(2'b11, 4'b1100, 4'b1010, 3'b110, 4'b1100, 4'b1010, 3'b100, 0, 1'b0, "tie2");
    chk("tie2_const", 32'(last_rsp), 32'(4'b1110));
    do_txn(2'b11, 4'b0101, 4'b0011, 3'b010, 4'b1111, 4'b0000, 3'b000, 0, 1'b0, "tie3");

    do_txn(2'b01, 4'b1100, 4'b1010, 3'b010, 4'b0000, 4'b0000, 3'b000, 0, 1'b0, "basic");
    chk("basic_const", 32'(last_rsp), 32'(4'b1000));

    for (int k = 0; k < 8; k++) begin
      do_txn(2'b10, 4'b0000, 4'b0000, 3'b000, 4'b1100, 4'b1010, 3'(k), 0, 1'b0, "allops");
      chk($sformatf("allops_const%0d", k), 32'(last_rsp), 32'(exp_ops[k]));
    end

    do_txn(2'b01, 4'b1001, 4'b0110, 3'b100, 4'b0000, 4'b0000, 3'b000, 3, 1'b0, "stall");
    do_txn(2'b10, 4'b0000, 4'b0000, 3'b000, 4'b1010, 4'b0110, 3'b110, 1, 1'b1, "pulse");

    req_valid = 2'b00;
    repeat (2) begin
      @(posedge clk); #1;
      chk("novalid_ready", 32'(req_ready), 32'd0);
      chk("novalid_busy", 32'(busy), 32'd0);
    end

    // Asynchronous reset during the second RUN cycle of a req1 operation.
    req_valid = 2'b10;
    req_a     = {4'b1111, 4'b0000};
    req_b     = {4'b1111, 4'b0000};
    req_op    = {3'b010, 3'b000};
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("rst_pre_busy", 32'(busy), 32'd1);
    chk("rst_pre_id", 32'(rsp_id), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk); #1;
    rst_n  = 1'b1;
    m_last = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      chk("midrst_norsp", 32'(rsp_valid), 32'd0);
    end
    do_txn(2'b11, 4'b0011, 4'b0101, 3'b111, 4'b1111, 4'b1111, 3'b001, 0, 1'b0, "rsttie");
    chk("rsttie_const", 32'(last_rsp), 32'(4'b1001));

    for (int r = 0; r < 40; r++) begin
      do_txn(2'($urandom_range(1, 3)),
             w_t'($urandom), w_t'($urandom), 3'($urandom),
             w_t'($urandom), w_t'($urandom), 3'($urandom),
             int'($urandom_range(0, 2)), 1'($urandom), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
